store_handler: RTL
==================

Name: store_handler

Overview:
- Write-back end of the operand path: accepts (result, destination address) pairs from the execute stage and commits them to data memory through a single write port.
- Buffers up to BUFFER_DEPTH pending stores in FIFO order. Drains one store per accepted memory cycle.
- Flags read-after-write hazards to the operand-fetch side.
- Supports a flush handshake so the controller can wait until every queued store has been committed.

Parameters:
- DATA_WIDTH, 8, width of stored data word
- DATA_MEMORY_SIZE, 64, number of data memory words; ADDR_W = $clog2(DATA_MEMORY_SIZE)
- BUFFER_DEPTH, 4, store queue entries; must be a power of two and at least 2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result_in/dst_in hold a store request
- in_ready  out  1  queue can accept a store this cycle
- result_in  in  DATA_WIDTH  data to store
- dst_in  in  ADDR_W  destination address
- mem_we  out  1  write request to data memory
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_WIDTH  write data
- mem_ack  in  1  memory accepts the presented write this cycle
- check_addr1  in  ADDR_W  source-1 address about to be read
- check_addr2  in  ADDR_W  source-2 address about to be read
- hazard  out  1  a pending store targets check_addr1 or check_addr2
- flush_req  in  1  request to drain the queue and block new stores
- flush_done  out  1  one-cycle pulse: flush complete
- count  out  $clog2(BUFFER_DEPTH)+1  number of valid entries

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_ptr, rd_ptr and count go to 0.
  - State goes to RUN; flush_done goes to 0.
  - All queued entries are discarded, including during a reset mid-drain.
- Outputs while in reset:
  - mem_we = 0 and hazard = 0.
  - in_ready = 1 once rst_n is high and the block is in RUN.
- Storage: circular buffer of {data, addr}. Pointers are ADDR-independent and wrap modulo BUFFER_DEPTH.
- Push:
  - Occurs when in_valid && in_ready.
  - Entry written at wr_ptr; wr_ptr advances on the rising edge.
- in_ready = (state == RUN) && (count < BUFFER_DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Memory side (combinational from the head entry):
  - mem_we = (count != 0).
  - mem_addr/mem_data = entry[rd_ptr].
- Pop:
  - Occurs when mem_we && mem_ack; rd_ptr advances.
  - mem_addr/mem_data must stay stable while mem_we is high and mem_ack is low.
- Latency: a store accepted at edge N appears on mem_* in the cycle after edge N. Minimum accept-to-commit is 1 cycle with mem_ack tied high.
- Simultaneous push and pop: count is unchanged, both pointers advance, and FIFO order is preserved.
- count updates:
  - +1 on push only.
  - -1 on pop only.
  - Never exceeds BUFFER_DEPTH and never underflows.
- hazard (combinational):
  - Set if any valid entry's addr equals check_addr1 or check_addr2.
  - Also set if the store being accepted this cycle (in_valid && in_ready) matches either check address.
  - An entry popped this cycle still counts as valid for hazard.
- State machine:
  - RUN: normal operation. flush_req=1 moves to FLUSH, or straight to DONE if count==0 and no push occurs this cycle.
  - FLUSH: in_ready=0; draining continues; moves to DONE when count==0, or when count==1 and a pop happens.
  - DONE: flush_done=1 for exactly one cycle, then return to RUN unconditionally. flush_req is then ignored until it has been sampled low and high again, i.e. flush_req is rising-edge qualified.
- A push accepted in the same cycle that flush_req first rises is kept and drained before flush_done.
- mem_ack while mem_we=0 is ignored.

Test Plan:
- Reset, then push (0xA5, addr 3) with mem_ack=1 -> next cycle mem_we=1, mem_addr=3, mem_data=0xA5; following cycle mem_we=0, count=0.
- mem_ack=0, push 4 stores (addr 1,2,3,4; data 0x11..0x44) -> count=4, in_ready=0, 5th in_valid not accepted; raise mem_ack -> writes appear in order 1,2,3,4, one per cycle.
- Full queue, simultaneous pop and in_valid -> in_ready stays 0 that cycle; next cycle count=3, in_ready=1.
- Queue holds addr 7, check_addr1=7 -> hazard=1. check_addr1=8 with check_addr2=7 -> hazard=1. After addr 7 is committed -> hazard=0. Empty queue with incoming dst_in=9 and check_addr2=9 -> hazard=1.
- Two entries queued with mem_ack=1, pulse flush_req -> in_ready=0 during drain, flush_done high for one cycle exactly 1 cycle after the last pop, then in_ready=1.
- Three entries queued, drop rst_n mid-drain -> mem_we=0 immediately; after release count=0 and no stale write is ever issued.

Source files
------------

// File: rtl/store_handler.sv
// Store queue between execute and data memory: buffers (data, addr) pairs in FIFO
// order, drains one per acknowledged write, flags RAW hazards and supports flushing.
module store_handler #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_MEMORY_SIZE = 64,
  parameter int BUFFER_DEPTH     = 4,
  localparam int ADDR_W          = $clog2(DATA_MEMORY_SIZE),
  localparam int PTR_W           = $clog2(BUFFER_DEPTH),
  localparam int CNT_W           = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [ADDR_W-1:0]     dst_in,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  input  logic [ADDR_W-1:0]     check_addr1,
  input  logic [ADDR_W-1:0]     check_addr2,
  output logic                  hazard,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic [CNT_W-1:0]      count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  flushReqPrev_q;
  logic                  flushDone_q;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] dataMem_q [BUFFER_DEPTH];
  logic [ADDR_W-1:0]     addrMem_q [BUFFER_DEPTH];

  logic push;
  logic pop;
  logic flushRise;

  // in_ready is held low during reset so nothing can be captured while entries are discarded
  assign in_ready   = rst_n && (state_q == RUN) && (count_q < CNT_W'(BUFFER_DEPTH));
  assign push       = in_valid && in_ready;
  assign mem_we     = (count_q != '0);
  assign pop        = mem_we && mem_ack;
  assign mem_addr   = addrMem_q[rdPtr_q];
  assign mem_data   = dataMem_q[rdPtr_q];
  assign flushRise  = flush_req && !flushReqPrev_q;
  assign flush_done = flushDone_q;
  assign count      = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(push);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // The head entry still counts while it is being popped, as does a store being accepted now
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot   = '0;
    hazard = 1'b0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      slot = rdPtr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          ((addrMem_q[slot] == check_addr1) || (addrMem_q[slot] == check_addr2))) begin
        hazard = 1'b1;
      end
    end
    if (push && ((dst_in == check_addr1) || (dst_in == check_addr2))) begin
      hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= result_in;
      addrMem_q[wrPtr_q] <= dst_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // flush_req is edge-qualified so a request still held high after DONE does not re-trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flushDone_q    <= 1'b0;
      flushReqPrev_q <= 1'b0;
    end else begin
      flushReqPrev_q <= flush_req;
      flushDone_q    <= 1'b0;
      case (state_q)
        RUN: begin
          if (flushRise) begin
            if ((count_q == '0) && !push) begin
              state_q     <= DONE;
              flushDone_q <= 1'b1;
            end else begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
            state_q     <= DONE;
            flushDone_q <= 1'b1;
          end
        end
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule
